riscv_sc_core_top: RTL and testbench

//  Top of a single-cycle RV32I core: PC register, instruction ROM, decoder, register file, ALU,

---
 rtl/riscv_sc_core_top.sv | 248 ++++++++++++++++++++++++
 tb/tb_riscv_sc_core_top.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_sc_core_top.sv
// riscv_sc_core_top: single-cycle RV32I core (LUI, AUIPC, JAL, JALR, branches,
// LW/SW, OP-IMM, OP). All decode, execute and memory reads are combinational.
// PC, register file and data memory update together on posedge clk.
// Ports:
//   clk : single clock, all state updates on the rising edge
//   rst : asynchronous active-high reset; clears PC, registers and data memory
// Sub-blocks:
//   PC           (riscv_sc_pc)      program counter, PC_out
//   inst_mem     (riscv_sc_imem)    instruction ROM mem[], loaded from outside the core
//   regFile      (riscv_sc_regfile) registers[0:31], x0 hard-wired to zero
//   datamem_unit (riscv_sc_dmem)    D_mem[], word addressed by addr[7:2]
// Both memories are indexed by address bits [7:2], so accesses wrap every 64 words.

module riscv_sc_pc (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    output logic [31:0] PC_out
);
    // Program counter: cleared by reset, otherwise takes the resolved next PC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_out <= 32'd0;
        end else begin
            PC_out <= next_pc;
        end
    end
endmodule

module riscv_sc_imem #(
    parameter int IMEM_DEPTH = 64
) (
    input  logic [5:0]  idx,
    output logic [31:0] rdata
);
    // Contents are preloaded by the environment and are deliberately not reset.
    logic [31:0] mem [0:IMEM_DEPTH-1];

    assign rdata = mem[idx];
endmodule

module riscv_sc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [4:0]  rd_addr,
    input  logic        rd_we,
    input  logic [31:0] rd_wdata,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data
);
    logic [31:0] registers [0:31];

    // Register array: asynchronous clear, edge write; writes to x0 are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= 32'd0;
            end
        end else if (rd_we && (rd_addr != 5'd0)) begin
            registers[rd_addr] <= rd_wdata;
        end
    end

    // Reads see the pre-edge value, so rs1 == rd uses the old operand.
    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : registers[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : registers[rs2_addr];
endmodule

module riscv_sc_dmem #(
    parameter int DMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  idx,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] D_mem [0:DMEM_DEPTH-1];

    // Data array: asynchronous clear, word write on the edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                D_mem[i] <= 32'd0;
            end
        end else if (we) begin
            D_mem[idx] <= wdata;
        end
    end

    assign rdata = D_mem[idx];
endmodule

module riscv_sc_core_top #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input  logic clk,
    input  logic rst
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    wire  [31:0] instruction_top;
    logic [31:0] pc_s, next_pc_s, pc_plus4_s;
    logic [6:0]  opcode_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [2:0]  funct3_s;
    logic [31:0] imm_i_s, imm_st_s, imm_b_s, imm_u_s, imm_j_s;
    logic [31:0] rs1_data_s, rs2_data_s, alu_b_s, alu_res_s;
    logic [31:0] dm_addr_s, dm_rdata_s, rd_wdata_s;
    logic        rd_we_s, dm_we_s, alu_alt_s;
    logic        addr_unused_s;

    function automatic logic [31:0] alu_fn(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b000: r = alt ? (a - b) : (a + b);
            3'b001: r = a << b[4:0];
            3'b010: r = {31'd0, ($signed(a) < $signed(b))};
            3'b011: r = {31'd0, (a < b)};
            3'b100: r = a ^ b;
            3'b101: begin
                // Kept as separate assignments so the arithmetic shift stays signed.
                if (alt) begin
                    r = $signed(a) >>> b[4:0];
                end else begin
                    r = a >> b[4:0];
                end
            end
            3'b110: r = a | b;
            3'b111: r = a & b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    function automatic logic branch_fn(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        logic t;
        case (f3)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    riscv_sc_pc PC (.clk(clk), .rst(rst), .next_pc(next_pc_s), .PC_out(pc_s));

    riscv_sc_imem #(.IMEM_DEPTH(IMEM_DEPTH)) inst_mem (
        .idx(pc_s[7:2]), .rdata(instruction_top));

    riscv_sc_regfile regFile (
        .clk(clk), .rst(rst), .rs1_addr(rs1_s), .rs2_addr(rs2_s), .rd_addr(rd_s),
        .rd_we(rd_we_s), .rd_wdata(rd_wdata_s), .rs1_data(rs1_data_s), .rs2_data(rs2_data_s));

    riscv_sc_dmem #(.DMEM_DEPTH(DMEM_DEPTH)) datamem_unit (
        .clk(clk), .rst(rst), .idx(dm_addr_s[7:2]), .we(dm_we_s),
        .wdata(rs2_data_s), .rdata(dm_rdata_s));

    assign opcode_s   = instruction_top[6:0];
    assign rd_s       = instruction_top[11:7];
    assign funct3_s   = instruction_top[14:12];
    assign rs1_s      = instruction_top[19:15];
    assign rs2_s      = instruction_top[24:20];
    assign imm_i_s    = {{20{instruction_top[31]}}, instruction_top[31:20]};
    assign imm_st_s   = {{20{instruction_top[31]}}, instruction_top[31:25], instruction_top[11:7]};
    assign imm_b_s    = {{19{instruction_top[31]}}, instruction_top[31], instruction_top[7],
                         instruction_top[30:25], instruction_top[11:8], 1'b0};
    assign imm_u_s    = {instruction_top[31:12], 12'd0};
    assign imm_j_s    = {{11{instruction_top[31]}}, instruction_top[31], instruction_top[19:12],
                         instruction_top[20], instruction_top[30:21], 1'b0};
    assign pc_plus4_s = pc_s + 32'd4;

    // Bit 30 selects SUB only for register-register ops, but SRA/SRAI for both forms.
    assign alu_alt_s  = instruction_top[30] & ((opcode_s == OPC_OP) | (funct3_s == 3'b101));
    assign alu_b_s    = (opcode_s == OPC_OP) ? rs2_data_s : imm_i_s;
    assign alu_res_s  = alu_fn(funct3_s, alu_alt_s, rs1_data_s, alu_b_s);
    assign dm_addr_s  = rs1_data_s + ((opcode_s == OPC_STORE) ? imm_st_s : imm_i_s);

    // Only the word index of the data address matters; byte offset and upper bits wrap away.
    assign addr_unused_s = ^{dm_addr_s[31:8], dm_addr_s[1:0]};

    // Control: next PC, register write-back and store enable for the current instruction
    always_comb begin
        next_pc_s  = pc_plus4_s;
        rd_we_s    = 1'b0;
        rd_wdata_s = alu_res_s;
        dm_we_s    = 1'b0;
        case (opcode_s)
            OPC_LUI: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = imm_u_s;
            end
            OPC_AUIPC: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = pc_s + imm_u_s;
            end
            OPC_JAL: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = pc_plus4_s;
                next_pc_s  = pc_s + imm_j_s;
            end
            OPC_JALR: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = pc_plus4_s;
                next_pc_s  = (rs1_data_s + imm_i_s) & ~32'd1;
            end
            OPC_BRANCH: begin
                if (branch_fn(funct3_s, rs1_data_s, rs2_data_s)) begin
                    next_pc_s = pc_s + imm_b_s;
                end else begin
                    next_pc_s = pc_plus4_s;
                end
            end
            OPC_LOAD: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = dm_rdata_s;
            end
            OPC_STORE: begin
                dm_we_s = 1'b1;
            end
            OPC_OPIMM, OPC_OP: begin
                rd_we_s = 1'b1;
            end
            // Unknown opcodes (including the all-zero word) retire as a NOP.
            default: begin
                rd_we_s = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_riscv_sc_core_top.sv
module tb_riscv_sc_core_top;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_sc_core_top #(.IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut (.clk(clk), .rst(rst));

    int vectors = 0;
    int miscompares = 0;

    // Architectural reference state (instruction-set level interpreter)
    logic [31:0]        m_imem [64];
    logic [31:0]        m_pc;
    logic [31:0][31:0]  m_regs;
    logic [63:0][31:0]  m_dmem;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0][31:0] regs;
        logic [63:0][31:0] dmem;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] prog[$];

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int sh;
        sh = int'(b % 32);
        case (f3)
            3'd0: r = alt ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                if (alt) r = $signed(a) >>> sh;
                else     r = a >> sh;
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Executes one instruction on the reference state
    task automatic model_step();
        logic [31:0] ins, a, b, val, npc, ii, is_, ib, ij, addr;
        logic [4:0]  rd;
        logic [2:0]  f3;
        bit wr;
        ins = m_imem[m_pc[7:2]];
        rd  = ins[11:7];
        f3  = ins[14:12];
        a   = m_regs[ins[19:15]];
        b   = m_regs[ins[24:20]];
        ii  = 32'($signed(ins[31:20]));
        is_ = 32'($signed({ins[31:25], ins[11:7]}));
        ib  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        ij  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        npc = m_pc + 32'd4;
        wr  = 1'b0;
        val = 32'd0;
        case (ins[6:0])
            7'h37: begin wr = 1'b1; val = ins & 32'hFFFF_F000; end
            7'h17: begin wr = 1'b1; val = m_pc + (ins & 32'hFFFF_F000); end
            7'h6F: begin wr = 1'b1; val = m_pc + 32'd4; npc = m_pc + ij; end
            7'h67: begin wr = 1'b1; val = m_pc + 32'd4; npc = (a + ii) & ~32'd1; end
            7'h63: if (ref_taken(f3, a, b)) npc = m_pc + ib;
            7'h03: begin wr = 1'b1; addr = a + ii; val = m_dmem[addr[7:2]]; end
            7'h23: begin addr = a + is_; m_dmem[addr[7:2]] = b; end
            7'h13: begin wr = 1'b1; val = ref_alu(f3, (f3 == 3'd5) && ins[30], a, ii); end
            7'h33: begin wr = 1'b1; val = ref_alu(f3, ins[30], a, b); end
            default: wr = 1'b0;
        endcase
        if (wr && rd != 5'd0) m_regs[rd] = val;
        m_pc = npc;
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Monitor: after every active edge compare the DUT state with the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            int bad_r, bad_d;
            mon_e = exp_q.pop_front();
            check32("pc", dut.PC.PC_out, mon_e.pc);
            bad_r = -1;
            for (int i = 31; i >= 0; i--)
                if (dut.regFile.registers[i] !== mon_e.regs[i]) bad_r = i;
            vectors++;
            if (bad_r >= 0) begin
                miscompares++;
                $display("FAIL regfile x%0d: got 0x%08h expected 0x%08h", bad_r,
                         dut.regFile.registers[bad_r], mon_e.regs[bad_r]);
            end
            bad_d = -1;
            for (int i = 63; i >= 0; i--)
                if (dut.datamem_unit.D_mem[i] !== mon_e.dmem[i]) bad_d = i;
            vectors++;
            if (bad_d >= 0) begin
                miscompares++;
                $display("FAIL dmem[%0d]: got 0x%08h expected 0x%08h", bad_d,
                         dut.datamem_unit.D_mem[bad_d], mon_e.dmem[bad_d]);
            end
        end
    end

    task automatic model_reset();
        m_pc   = 32'd0;
        m_regs = '0;
        m_dmem = '0;
    endtask

    // Loads a program under reset; returns just before the edge that executes mem[0]
    task automatic start_prog();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            m_imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
            dut.inst_mem.mem[i] = m_imem[i];
        end
        model_reset();
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            exp_q.push_back({m_pc, m_regs, m_dmem});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_zero_state(input string tag);
        logic [31:0] acc_r, acc_d;
        acc_r = 32'd0;
        acc_d = 32'd0;
        for (int i = 0; i < 32; i++) acc_r |= dut.regFile.registers[i];
        for (int i = 0; i < 64; i++) acc_d |= dut.datamem_unit.D_mem[i];
        check32({tag, "_pc"}, dut.PC.PC_out, 32'd0);
        check32({tag, "_regs_or"}, acc_r, 32'd0);
        check32({tag, "_dmem_or"}, acc_d, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2, sh;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic        alt;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        sh  = 5'($urandom);
        imm = 12'($urandom);
        alt = 1'($urandom);
        f3  = 3'($urandom);
        case ($urandom_range(0, 11))
            0: return {20'($urandom), rd, 7'h37};
            1: return {20'($urandom), rd, 7'h17};
            2: return enc_j(21'($urandom_range(0, 31) * 4) - 21'd64, rd);
            3: return enc_i(imm, rs1, 3'd0, rd, 7'h67);
            4: begin
                f3 = 3'($urandom_range(0, 5));
                if (f3 >= 3'd2) f3 = f3 + 3'd2;
                return enc_b(13'($urandom_range(0, 31) * 4) - 13'd64, rs2, rs1, f3);
            end
            5: return enc_i(imm, rs1, 3'd2, rd, 7'h03);
            6: return enc_s(imm, rs2, rs1);
            7, 8: begin
                if (f3 == 3'd1) imm = {7'd0, sh};
                else if (f3 == 3'd5) imm = {1'b0, alt, 5'd0, sh};
                return enc_i(imm, rs1, f3, rd, 7'h13);
            end
            9, 10: return enc_r((f3 == 3'd0 || f3 == 3'd5) ? {1'b0, alt, 5'd0} : 7'd0,
                                rs2, rs1, f3, rd);
            default: return $urandom_range(0, 1) ? 32'd0 : {25'($urandom), 7'h0B};
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state before any clock edge
        #1;
        check_zero_state("reset");

        // Add of two immediates
        prog.delete();
        prog.push_back(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));
        prog.push_back(enc_i(12'd7, 5'd0, 3'd0, 5'd2, 7'h13));
        prog.push_back(enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd10));
        start_prog();
        run_cycles(3);
        check32("add_x10", dut.regFile.registers[10], 32'd12);
        check32("add_pc", dut.PC.PC_out, 32'd12);

        // Store then load round trip
        prog.delete();
        prog.push_back(enc_i(12'd42, 5'd0, 3'd0, 5'd1, 7'h13));
        prog.push_back(enc_s(12'd0, 5'd1, 5'd0));
        prog.push_back(enc_i(12'd0, 5'd0, 3'd2, 5'd10, 7'h03));
        start_prog();
        run_cycles(3);
        check32("sw_dmem0", dut.datamem_unit.D_mem[0], 32'd42);
        check32("lw_x10", dut.regFile.registers[10], 32'd42);

        // Taken branch skips the poisoned instruction
        prog.delete();
        prog.push_back(enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13));
        prog.push_back(enc_b(13'd8, 5'd1, 5'd1, 3'd0));
        prog.push_back(enc_i(12'd99, 5'd0, 3'd0, 5'd10, 7'h13));
        prog.push_back(enc_i(12'd3, 5'd0, 3'd0, 5'd10, 7'h13));
        start_prog();
        run_cycles(3);
        check32("beq_x10", dut.regFile.registers[10], 32'd3);
        check32("beq_pc", dut.PC.PC_out, 32'd16);

        // JAL link and JALR return
        prog.delete();
        prog.push_back(enc_j(21'd8, 5'd1));
        prog.push_back(32'd0);
        prog.push_back(enc_i(12'd0, 5'd1, 3'd0, 5'd0, 7'h67));
        start_prog();
        run_cycles(1);
        check32("jal_x1", dut.regFile.registers[1], 32'd4);
        check32("jal_pc", dut.PC.PC_out, 32'd8);
        run_cycles(1);
        check32("jalr_pc", dut.PC.PC_out, 32'd4);

        // x0 write dropped; logical shift of all-ones
        prog.delete();
        prog.push_back(enc_i(12'd9, 5'd0, 3'd0, 5'd0, 7'h13));
        prog.push_back(enc_i(12'hFFF, 5'd0, 3'd0, 5'd10, 7'h13));
        prog.push_back(enc_i(12'd28, 5'd10, 3'd5, 5'd10, 7'h13));
        start_prog();
        run_cycles(3);
        check32("x0_zero", dut.regFile.registers[0], 32'd0);
        check32("srli_x10", dut.regFile.registers[10], 32'd15);

        // Asynchronous reset between edges, then rerun from mem[0]
        prog.delete();
        prog.push_back(enc_i(12'd42, 5'd0, 3'd0, 5'd1, 7'h13));
        prog.push_back(enc_s(12'd0, 5'd1, 5'd0));
        prog.push_back(enc_i(12'd0, 5'd0, 3'd2, 5'd10, 7'h03));
        start_prog();
        run_cycles(2);
        rst = 1'b1;
        #1;
        check_zero_state("midrst");
        rst = 1'b0;
        model_reset();
        run_cycles(3);
        check32("rerun_x10", dut.regFile.registers[10], 32'd42);
        check32("rerun_pc", dut.PC.PC_out, 32'd12);

        // Random programs against the reference interpreter
        for (int p = 0; p < 6; p++) begin
            prog.delete();
            for (int i = 0; i < 64; i++) prog.push_back(rand_instr());
            start_prog();
            run_cycles(150);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
